// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with two read ports, INC and multi-cycle CLRALL
module reg_file_param #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic             RegCE,
  input  logic [1:0]       Op,
  input  logic [AW-1:0]    RegNum,
  input  logic [AW-1:0]    RdAddrA,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             Busy,
  output logic             Carry
);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INC    = 2'b10;
  localparam logic [1:0] OP_CLRALL = 2'b11;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] regs [DEPTH];
  logic             accept;
  logic             sel_hit;
  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] inc_val;

  // Out-of-range addresses match no entry and therefore read zero.
  always_comb begin
    OutA    = '0;
    OutB    = '0;
    sel_hit = 1'b0;
    sel_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddrA == AW'(i)) OutA = regs[i];
      if (RdAddrB == AW'(i)) OutB = regs[i];
      if (RegNum == AW'(i)) begin
        sel_hit = 1'b1;
        sel_val = regs[i];
      end
    end
  end

  assign inc_val = sel_val + WIDTH'(1);
  assign Busy    = (state == CLEAR);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = RegCE;
        if (RegCE && Op == OP_CLRALL && DEPTH > 1) state_next = CLEAR;
      end
      CLEAR: begin
        if (idx == LAST_IDX) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
      Carry <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (idx == AW'(i)) regs[i] <= '0;
        end
        idx <= (idx == LAST_IDX) ? '0 : idx + AW'(1);
      end else if (accept) begin
        case (Op)
          OP_NOP: ;
          OP_WRITE: begin
            for (int i = 0; i < DEPTH; i++) begin
              if (RegNum == AW'(i)) regs[i] <= A;
            end
          end
          OP_INC: begin
            // Carry reports the pre-increment all-ones condition, only for valid targets.
            if (sel_hit) begin
              Carry <= &sel_val;
              for (int i = 0; i < DEPTH; i++) begin
                if (RegNum == AW'(i)) regs[i] <= inc_val;
              end
            end
          end
          OP_CLRALL: begin
            regs[0] <= '0;
            Carry   <= 1'b0;
            if (DEPTH > 1) idx <= AW'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed vector bench for reg_file_param (4x8 and 6x4 instances)
module tb_reg_file_param;

  localparam logic [1:0] NOP = 2'b00, WR = 2'b01, INC = 2'b10, CLR = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a4;
  logic       ce4;
  logic [1:0] op4;
  logic [1:0] num4, ra4, rb4;
  logic [7:0] outa4, outb4;
  logic       busy4, carry4;

  logic [3:0] a6;
  logic       ce6;
  logic [1:0] op6;
  logic [2:0] num6, ra6, rb6;
  logic [3:0] outa6, outb6;
  logic       busy6, carry6;

  reg_file_param #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .Reset(rst), .A(a4), .RegCE(ce4), .Op(op4), .RegNum(num4),
    .RdAddrA(ra4), .RdAddrB(rb4), .OutA(outa4), .OutB(outb4), .Busy(busy4), .Carry(carry4)
  );

  reg_file_param #(.WIDTH(4), .DEPTH(6)) dut6 (
    .clk(clk), .Reset(rst), .A(a6), .RegCE(ce6), .Op(op6), .RegNum(num6),
    .RdAddrA(ra6), .RdAddrB(rb6), .OutA(outa6), .OutB(outb6), .Busy(busy6), .Carry(carry6)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic ce, input logic [1:0] op, input logic [1:0] num,
                        input logic [7:0] a, input logic [1:0] ra, input logic [1:0] rb);
    @(negedge clk);
    ce4 = ce; op4 = op; num4 = num; a4 = a; ra4 = ra; rb4 = rb;
  endtask

  task automatic drive6(input logic ce, input logic [1:0] op, input logic [2:0] num,
                        input logic [3:0] a, input logic [2:0] ra, input logic [2:0] rb);
    @(negedge clk);
    ce6 = ce; op6 = op; num6 = num; a6 = a; ra6 = ra; rb6 = rb;
  endtask

  typedef struct {
    logic       ce;
    logic [1:0] op;
    logic [1:0] num;
    logic [7:0] a;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] pre_a;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_busy;
    logic       exp_carry;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int cnt;

    vecs[0]  = '{1'b1, WR,  2'd0, 8'h04, 2'd0, 2'd3, 8'h00, 8'h04, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, WR,  2'd1, 8'h05, 2'd1, 2'd0, 8'h00, 8'h05, 8'h04, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, WR,  2'd2, 8'h06, 2'd2, 2'd1, 8'h00, 8'h06, 8'h05, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, WR,  2'd3, 8'h07, 2'd3, 2'd2, 8'h00, 8'h07, 8'h06, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, NOP, 2'd0, 8'hEE, 2'd2, 2'd3, 8'h06, 8'h06, 8'h07, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, WR,  2'd1, 8'hFF, 2'd1, 2'd0, 8'h05, 8'hFF, 8'h04, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, INC, 2'd1, 8'h00, 2'd1, 2'd0, 8'hFF, 8'h00, 8'h04, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, INC, 2'd1, 8'h00, 2'd1, 2'd0, 8'h00, 8'h01, 8'h04, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, WR,  2'd2, 8'h09, 2'd2, 2'd1, 8'h06, 8'h09, 8'h01, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, WR,  2'd1, 8'hFF, 2'd1, 2'd2, 8'h01, 8'hFF, 8'h09, 1'b0, 1'b0};
    vecs[10] = '{1'b1, INC, 2'd1, 8'h00, 2'd1, 2'd2, 8'hFF, 8'h00, 8'h09, 1'b0, 1'b1};
    vecs[11] = '{1'b1, WR,  2'd2, 8'h33, 2'd2, 2'd1, 8'h09, 8'h33, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{1'b0, WR,  2'd0, 8'h55, 2'd0, 2'd1, 8'h04, 8'h04, 8'h00, 1'b0, 1'b1};
    vecs[13] = '{1'b1, NOP, 2'd0, 8'h00, 2'd0, 2'd3, 8'h04, 8'h04, 8'h07, 1'b0, 1'b1};

    rst = 1'b1;
    ce4 = 1'b0; op4 = NOP; num4 = '0; a4 = '0; ra4 = '0; rb4 = '0;
    ce6 = 1'b0; op6 = NOP; num6 = '0; a6 = '0; ra6 = '0; rb6 = '0;
    tick();
    tick();

    for (int i = 0; i < 4; i++) begin
      ra4 = 2'(i); rb4 = 2'(3 - i);
      #1;
      chk("rst_outa", outa4, 0);
      chk("rst_outb", outb4, 0);
    end
    chk("rst_busy", busy4, 0);
    chk("rst_carry", carry4, 0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive4(vecs[i].ce, vecs[i].op, vecs[i].num, vecs[i].a, vecs[i].ra, vecs[i].rb);
      #1;
      chk($sformatf("v%0d_pre_a", i), outa4, vecs[i].pre_a);
      tick();
      chk($sformatf("v%0d_outa", i), outa4, vecs[i].exp_a);
      chk($sformatf("v%0d_outb", i), outb4, vecs[i].exp_b);
      chk($sformatf("v%0d_busy", i), busy4, vecs[i].exp_busy);
      chk($sformatf("v%0d_carry", i), carry4, vecs[i].exp_carry);
    end

    // CLRALL with regs 4,5,6,7 and a WRITE attempted while busy
    drive4(1'b1, WR, 2'd1, 8'h05, 2'd0, 2'd1); tick();
    drive4(1'b1, WR, 2'd2, 8'h06, 2'd0, 2'd1); tick();
    drive4(1'b1, CLR, 2'd0, 8'h00, 2'd0, 2'd1);
    #1 chk("clr_pre_busy", busy4, 0);
    tick();
    chk("clr_e0_busy", busy4, 1);
    chk("clr_e0_r0", outa4, 8'h00);
    chk("clr_e0_r1", outb4, 8'h05);
    chk("clr_e0_carry", carry4, 0);
    drive4(1'b1, WR, 2'd0, 8'hAA, 2'd1, 2'd2); tick();
    chk("clr_e1_busy", busy4, 1);
    chk("clr_e1_r1", outa4, 8'h00);
    chk("clr_e1_r2", outb4, 8'h06);
    drive4(1'b1, WR, 2'd0, 8'hAA, 2'd2, 2'd3); tick();
    chk("clr_e2_busy", busy4, 1);
    chk("clr_e2_r2", outa4, 8'h00);
    chk("clr_e2_r3", outb4, 8'h07);
    drive4(1'b1, WR, 2'd0, 8'hAA, 2'd3, 2'd0); tick();
    chk("clr_e3_busy", busy4, 0);
    chk("clr_e3_r3", outa4, 8'h00);
    chk("clr_e3_r0_dropped", outb4, 8'h00);
    drive4(1'b0, NOP, 2'd0, 8'h00, 2'd0, 2'd0);

    // reset in the second CLEAR cycle
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, WR, 2'(i), 8'(i + 1), 2'd0, 2'd0);
      tick();
    end
    drive4(1'b1, CLR, 2'd0, 8'h00, 2'd3, 2'd2); tick();
    chk("rmid_c1_busy", busy4, 1);
    drive4(1'b0, NOP, 2'd0, 8'h00, 2'd3, 2'd2); tick();
    chk("rmid_c2_busy", busy4, 1);
    chk("rmid_c2_r3", outa4, 8'h04);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rmid_busy", busy4, 0);
    for (int i = 0; i < 4; i++) begin
      ra4 = 2'(i);
      #1 chk($sformatf("rmid_r%0d", i), outa4, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    ce4 = 1'b1; op4 = WR; num4 = 2'd3; a4 = 8'h11; ra4 = 2'd3;
    tick();
    chk("rmid_wr_r3", outa4, 8'h11);
    chk("rmid_wr_busy", busy4, 0);
    drive4(1'b0, NOP, 2'd0, 8'h00, 2'd0, 2'd0);

    // DEPTH=6, WIDTH=4 instance
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    drive6(1'b1, WR, 3'd5, 4'hF, 3'd5, 3'd4); tick();
    drive6(1'b1, WR, 3'd4, 4'h3, 3'd5, 3'd4); tick();
    chk("d6_r5", outa6, 4'hF);
    chk("d6_r4", outb6, 4'h3);
    drive6(1'b1, WR, 3'd7, 4'hF, 3'd7, 3'd6); tick();
    chk("d6_oor_r7", outa6, 4'h0);
    chk("d6_oor_r6", outb6, 4'h0);
    ra6 = 3'd5;
    #1 chk("d6_oor_r5_kept", outa6, 4'hF);
    drive6(1'b1, INC, 3'd5, 4'h0, 3'd5, 3'd4); tick();
    chk("d6_inc_r5", outa6, 4'h0);
    chk("d6_inc_carry", carry6, 1);
    drive6(1'b1, INC, 3'd7, 4'h0, 3'd5, 3'd4); tick();
    chk("d6_inc_oor_carry", carry6, 1);
    chk("d6_inc_oor_r5", outa6, 4'h0);
    drive6(1'b1, WR, 3'd5, 4'h9, 3'd5, 3'd4); tick();
    drive6(1'b1, CLR, 3'd0, 4'h0, 3'd5, 3'd4); tick();
    drive6(1'b0, NOP, 3'd0, 4'h0, 3'd5, 3'd4);
    #1;
    cnt = 0;
    while (busy6 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("d6_busy_cycles", 32'(cnt), 5);
    chk("d6_clr_r5", outa6, 4'h0);
    chk("d6_clr_r4", outb6, 4'h0);
    chk("d6_clr_carry", carry6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
